// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the Tuse/Tnew hazard scoreboard.
//
// Contents:
//   AW_MAX/TW_MAX  storage widths of the entry fields; narrower parameters zero-extend
//   TUSE_NONE      Tuse code meaning "operand not read" (all-ones at the default width)
//   FWD_RF         forward select meaning "no forwarding, use regfile / own value"
//   MUL_LAT_DEF    default mult/multu MD-unit occupancy
//   DIV_LAT_DEF    default div/divu MD-unit occupancy
//   sb_entry_t     one scoreboard entry (one per pipeline stage after D)
package hazard_pkg;

    localparam int unsigned AW_MAX      = 8;
    localparam int unsigned TW_MAX      = 8;
    localparam int unsigned TW_DEF      = 3;

    localparam logic [TW_DEF-1:0] TUSE_NONE = '1;

    localparam int unsigned FWD_RF      = 0;

    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [AW_MAX-1:0] waddr;
        logic [TW_MAX-1:0] tnew;     // cycles until the result can be forwarded
        logic [AW_MAX-1:0] rs;
        logic [AW_MAX-1:0] rt;
        logic              md_start;
        logic              md_div;
    } sb_entry_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage request bundle and hazard responses.
//
// master modport: pipeline side, drives the D-stage instruction description and flush,
//                 receives stall, forwarding selects and md_busy.
// slave modport:  scoreboard side, the mirror image.
//
// Signals:
//   d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_waddr, d_tnew,
//   d_md_start, d_md_div, d_md_use, flush                    pipeline -> scoreboard
//   stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy   scoreboard -> pipeline
interface hazard_scoreboard_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 3,
    parameter int unsigned SW = 2
);

    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_rs_tuse;
    logic [TW-1:0] d_rt_tuse;
    logic          d_we;
    logic [AW-1:0] d_waddr;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_md_use;
    logic          flush;

    logic          stall;
    logic [SW-1:0] fwd_d_rs;
    logic [SW-1:0] fwd_d_rt;
    logic [SW-1:0] fwd_e_rs;
    logic [SW-1:0] fwd_e_rt;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_waddr, d_tnew,
               d_md_start, d_md_div, d_md_use, flush,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_waddr, d_tnew,
               d_md_start, d_md_div, d_md_use, flush,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
    );

endinterface

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: multiply/divide unit occupancy timer.
//
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset, clears the count
//   start    load the timer this edge (mult/div class leaving E)
//   div      with start: load DIV_LAT instead of MUL_LAT
//   busy     count is nonzero
module hazard_md_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int unsigned MAX_LAT = max_u(MUL_LAT, DIV_LAT);
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew hazard controller beside the D stage.
//
// Tracks one entry per stage after D (entry 0 = E, 1 = M, 2 = W, ...), each carrying
// the writer's destination and a Tnew countdown. From that it derives the D-stage stall
// and the forward selects for the D and E operand muxes. An MD-unit timer covers
// HI/LO hazards behind mult/div.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   hz (slave)     D-stage instruction description and flush in; stall,
//                  fwd_d_rs/rt (0 = regfile, k = entry k-1),
//                  fwd_e_rs/rt (0 = own value, k = entry k) and md_busy out
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = $clog2(NREG),
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned TW      = 3,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned SW      = $clog2(NSTAGE + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    hazard_scoreboard_if.slave hz
);

    sb_entry_t ent_q [NSTAGE];
    sb_entry_t ent_d [NSTAGE];

    logic              d_rs_hit, d_rt_hit, e_rs_hit, e_rt_hit;
    logic [TW_MAX-1:0] d_rs_tnew, d_rt_tnew, e_rs_tnew, e_rt_tnew;
    logic [SW-1:0]     d_rs_code, d_rt_code, e_rs_code, e_rt_code;
    logic              rs_stall, rt_stall, md_stall, stall;
    logic              md_busy, md_load;

    // Register 0 is hardwired, so a writer to it never creates a dependency.
    function automatic logic hit(input sb_entry_t e, input logic [AW_MAX-1:0] r);
        return e.valid && e.we && (r != '0) && (e.waddr == r);
    endfunction

    function automatic logic [TW_MAX-1:0] sat_dec(input logic [TW_MAX-1:0] t);
        return (t == '0) ? '0 : t - TW_MAX'(1);
    endfunction

    // Priority encoders: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        d_rs_hit  = 1'b0;
        d_rt_hit  = 1'b0;
        e_rs_hit  = 1'b0;
        e_rt_hit  = 1'b0;
        d_rs_tnew = '0;
        d_rt_tnew = '0;
        e_rs_tnew = '0;
        e_rt_tnew = '0;
        d_rs_code = '0;
        d_rt_code = '0;
        e_rs_code = '0;
        e_rt_code = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (hit(ent_q[k], AW_MAX'(hz.d_rs))) begin
                d_rs_hit  = 1'b1;
                d_rs_tnew = ent_q[k].tnew;
                d_rs_code = SW'(k + 1);
            end
            if (hit(ent_q[k], AW_MAX'(hz.d_rt))) begin
                d_rt_hit  = 1'b1;
                d_rt_tnew = ent_q[k].tnew;
                d_rt_code = SW'(k + 1);
            end
        end
        // E-stage operands only look past E itself; a bubble in E holds rs = rt = 0.
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (hit(ent_q[k], ent_q[0].rs)) begin
                e_rs_hit  = 1'b1;
                e_rs_tnew = ent_q[k].tnew;
                e_rs_code = SW'(k);
            end
            if (hit(ent_q[k], ent_q[0].rt)) begin
                e_rt_hit  = 1'b1;
                e_rt_tnew = ent_q[k].tnew;
                e_rt_code = SW'(k);
            end
        end
    end

    assign rs_stall = d_rs_hit && (hz.d_rs_tuse != {TW{1'b1}}) &&
                      (d_rs_tnew > TW_MAX'(hz.d_rs_tuse));
    assign rt_stall = d_rt_hit && (hz.d_rt_tuse != {TW{1'b1}}) &&
                      (d_rt_tnew > TW_MAX'(hz.d_rt_tuse));
    // A mult/div sitting in E has not loaded the timer yet, so it blocks on its own.
    assign md_stall = hz.d_md_use && (md_busy || (ent_q[0].valid && ent_q[0].md_start));
    assign stall    = hz.d_valid && (rs_stall || rt_stall || md_stall);

    assign hz.stall    = stall;
    assign hz.md_busy  = md_busy;
    assign hz.fwd_d_rs = (d_rs_hit && d_rs_tnew == '0) ? d_rs_code : SW'(FWD_RF);
    assign hz.fwd_d_rt = (d_rt_hit && d_rt_tnew == '0) ? d_rt_code : SW'(FWD_RF);
    assign hz.fwd_e_rs = (e_rs_hit && e_rs_tnew == '0) ? e_rs_code : SW'(FWD_RF);
    assign hz.fwd_e_rt = (e_rt_hit && e_rt_tnew == '0) ? e_rt_code : SW'(FWD_RF);

    // Invalid entries are kept all-zero so stale fields can never match.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            ent_d[k] = '0;
        end
        if (!hz.flush) begin
            if (hz.d_valid && !stall) begin
                ent_d[0].valid    = 1'b1;
                ent_d[0].we       = hz.d_we;
                ent_d[0].waddr    = AW_MAX'(hz.d_waddr);
                ent_d[0].tnew     = TW_MAX'(hz.d_tnew);
                ent_d[0].rs       = AW_MAX'(hz.d_rs);
                ent_d[0].rt       = AW_MAX'(hz.d_rt);
                ent_d[0].md_start = hz.d_md_start;
                ent_d[0].md_div   = hz.d_md_div;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                ent_d[k]      = ent_q[k-1];
                ent_d[k].tnew = sat_dec(ent_q[k-1].tnew);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

    // Flush kills the mult/div before it launches, but never stops a running count.
    assign md_load = ent_q[0].valid && ent_q[0].md_start && !hz.flush;

    hazard_md_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_load),
        .div     (ent_q[0].md_div),
        .busy    (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int unsigned NREG   = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NSTAGE = 3;
    localparam int unsigned TW     = 3;
    localparam int unsigned SW     = 2;
    localparam int          MUL    = 5;
    localparam int          DIV    = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(AW), .TW(TW), .SW(SW)) hz ();

    hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .NSTAGE(NSTAGE), .TW(TW),
        .MUL_LAT(MUL), .DIV_LAT(DIV), .SW(SW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what instruction sits in each stage, its Tnew at entry to E,
    // and the remaining MD-unit occupancy. Age in the pipe equals the stage index.
    int mv [NSTAGE];
    int mwe[NSTAGE];
    int mwa[NSTAGE];
    int mt0[NSTAGE];
    int mrs[NSTAGE];
    int mrt[NSTAGE];
    int mms[NSTAGE];
    int mmd[NSTAGE];
    int md_rem;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rem(input int k);
        return (mt0[k] > k) ? mt0[k] - k : 0;
    endfunction

    function automatic int youngest(input int r, input int lo);
        for (int k = lo; k < NSTAGE; k++)
            if (r != 0 && mv[k] != 0 && mwe[k] != 0 && mwa[k] == r) return k;
        return -1;
    endfunction

    function automatic int exp_stall();
        int hs, ht, s;
        hs = youngest(int'(hz.d_rs), 0);
        ht = youngest(int'(hz.d_rt), 0);
        s  = 0;
        if (hs >= 0 && hz.d_rs_tuse != TUSE_NONE && rem(hs) > int'(hz.d_rs_tuse)) s = 1;
        if (ht >= 0 && hz.d_rt_tuse != TUSE_NONE && rem(ht) > int'(hz.d_rt_tuse)) s = 1;
        if (hz.d_md_use && (md_rem > 0 || (mv[0] != 0 && mms[0] != 0))) s = 1;
        return (hz.d_valid && s != 0) ? 1 : 0;
    endfunction

    function automatic int exp_fwd_d(input int r);
        int k;
        k = youngest(r, 0);
        return (k >= 0 && rem(k) == 0) ? k + 1 : 0;
    endfunction

    function automatic int exp_fwd_e(input int r);
        int k;
        if (mv[0] == 0) return 0;
        k = youngest(r, 1);
        return (k >= 0 && rem(k) == 0) ? k : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NSTAGE; k++) begin
            mv[k] = 0; mwe[k] = 0; mwa[k] = 0; mt0[k] = 0;
            mrs[k] = 0; mrt[k] = 0; mms[k] = 0; mmd[k] = 0;
        end
        md_rem = 0;
    endtask

    task automatic model_step(input int st);
        int nm;
        nm = (md_rem > 0) ? md_rem - 1 : 0;
        if (mv[0] != 0 && mms[0] != 0 && !hz.flush) nm = (mmd[0] != 0) ? DIV : MUL;
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            mv[k] = mv[k-1]; mwe[k] = mwe[k-1]; mwa[k] = mwa[k-1]; mt0[k] = mt0[k-1];
            mrs[k] = mrs[k-1]; mrt[k] = mrt[k-1]; mms[k] = mms[k-1]; mmd[k] = mmd[k-1];
        end
        if (hz.d_valid && st == 0) begin
            mv[0] = 1; mwe[0] = int'(hz.d_we); mwa[0] = int'(hz.d_waddr);
            mt0[0] = int'(hz.d_tnew); mrs[0] = int'(hz.d_rs); mrt[0] = int'(hz.d_rt);
            mms[0] = int'(hz.d_md_start); mmd[0] = int'(hz.d_md_div);
        end else begin
            mv[0] = 0; mwe[0] = 0; mwa[0] = 0; mt0[0] = 0;
            mrs[0] = 0; mrt[0] = 0; mms[0] = 0; mmd[0] = 0;
        end
        if (hz.flush) for (int k = 0; k < NSTAGE; k++) mv[k] = 0;
        md_rem = nm;
    endtask

    task automatic drv(input int v, input int rs, input int rt, input int rsu, input int rtu,
                       input int we, input int wa, input int tn, input int ms, input int md,
                       input int mu, input int fl);
        hz.d_valid    = v[0];
        hz.d_rs       = AW'(rs);
        hz.d_rt       = AW'(rt);
        hz.d_rs_tuse  = TW'(rsu);
        hz.d_rt_tuse  = TW'(rtu);
        hz.d_we       = we[0];
        hz.d_waddr    = AW'(wa);
        hz.d_tnew     = TW'(tn);
        hz.d_md_start = ms[0];
        hz.d_md_div   = md[0];
        hz.d_md_use   = mu[0];
        hz.flush      = fl[0];
    endtask

    task automatic sample();
        @(negedge clk);
        chk("stall",    32'(hz.stall),    32'(exp_stall()));
        chk("fwd_d_rs", 32'(hz.fwd_d_rs), 32'(exp_fwd_d(int'(hz.d_rs))));
        chk("fwd_d_rt", 32'(hz.fwd_d_rt), 32'(exp_fwd_d(int'(hz.d_rt))));
        chk("fwd_e_rs", 32'(hz.fwd_e_rs), 32'(exp_fwd_e(mrs[0])));
        chk("fwd_e_rt", 32'(hz.fwd_e_rt), 32'(exp_fwd_e(mrt[0])));
        chk("md_busy",  32'(hz.md_busy),  32'((md_rem > 0) ? 1 : 0));
    endtask

    task automatic advance();
        int st;
        @(posedge clk);
        st = exp_stall();
        model_step(st);
        #1;
    endtask

    initial begin
        int nst, nbusy, done;
        model_reset();
        drv(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_stall",   32'(hz.stall),    32'd0);
        chk("rst_md_busy", 32'(hz.md_busy),  32'd0);
        chk("rst_fwd_d",   32'({hz.fwd_d_rs, hz.fwd_d_rt}), 32'd0);
        chk("rst_fwd_e",   32'({hz.fwd_e_rs, hz.fwd_e_rt}), 32'd0);
        #11 reset_n = 1'b1;

        // addu $3 (tnew 1) then beq reading $3 (tuse 0): one stall, then forward from M.
        drv(1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 0); sample(); advance();
        drv(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
        chk("t1_stall", 32'(hz.stall), 32'd1); advance();
        sample();
        chk("t1_nostall", 32'(hz.stall), 32'd0);
        chk("t1_fwd_d_rs", 32'(hz.fwd_d_rs), 32'd2); advance();

        // lw $5 (tnew 2) then addu using $5 (tuse 1): one stall, then fwd_e_rs = 2.
        drv(1, 1, 0, 1, 7, 1, 5, 2, 0, 0, 0, 0); sample(); advance();
        drv(1, 5, 6, 1, 1, 1, 8, 1, 0, 0, 0, 0); sample();
        chk("t2_stall", 32'(hz.stall), 32'd1); advance();
        sample();
        chk("t2_nostall", 32'(hz.stall), 32'd0); advance();
        drv(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0); sample();
        chk("t2_fwd_e_rs", 32'(hz.fwd_e_rs), 32'd2); advance();

        // Two writers of $7 in M and W: the younger one (M) is chosen.
        drv(1, 0, 0, 7, 7, 1, 7, 0, 0, 0, 0, 0); sample(); advance();
        sample(); advance();
        drv(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0); sample(); advance();
        drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
        chk("t3_fwd_d_rs", 32'(hz.fwd_d_rs), 32'd2);
        chk("t3_fwd_d_rt", 32'(hz.fwd_d_rt), 32'd0); advance();
        drv(1, 0, 0, 7, 7, 1, 0, 0, 0, 0, 0, 0); sample(); advance();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
        chk("t3_r0_fwd", 32'(hz.fwd_d_rs), 32'd0);
        chk("t3_r0_stall", 32'(hz.stall), 32'd0); advance();

        // div then mflo: stalls while div sits in E plus the full divide latency.
        drv(1, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 0); sample(); advance();
        drv(1, 0, 0, 7, 7, 1, 9, 1, 0, 0, 1, 0);
        nst = 0; nbusy = 0; done = 0;
        for (int i = 0; i < 30 && done == 0; i++) begin
            sample();
            if (hz.stall === 1'b1) begin
                nst++;
                if (hz.md_busy === 1'b1) nbusy++;
            end else begin
                done = 1;
            end
            advance();
        end
        chk("t4_stall_cycles", 32'(nst), 32'd11);
        chk("t4_busy_cycles", 32'(nbusy), 32'd10);

        // Flush with lw in E and dependent addu in D while a mult is counting.
        drv(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0); sample(); advance();
        drv(1, 1, 0, 1, 7, 1, 5, 2, 0, 0, 0, 0); sample(); advance();
        drv(1, 5, 0, 1, 7, 1, 6, 1, 0, 0, 0, 1); sample();
        chk("t5_stall_pre", 32'(hz.stall), 32'd1); advance();
        drv(1, 5, 0, 1, 7, 1, 6, 1, 0, 0, 0, 0); sample();
        chk("t5_stall_post", 32'(hz.stall), 32'd0);
        chk("t5_md_busy", 32'(hz.md_busy), 32'd1); advance();

        // Reset mid-div with mflo stalled in D: everything drops at once.
        drv(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin sample(); advance(); end
        drv(1, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 0); sample(); advance();
        drv(1, 0, 0, 7, 7, 1, 9, 1, 0, 0, 1, 0); sample(); advance();
        sample(); advance();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_stall", 32'(hz.stall), 32'd0);
        chk("t6_md_busy", 32'(hz.md_busy), 32'd0);
        chk("t6_fwd", 32'({hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt}), 32'd0);
        model_reset();
        #2 reset_n = 1'b1;
        sample();
        chk("t6_after_stall", 32'(hz.stall), 32'd0); advance();

        // Random traffic over a small register set so dependencies are frequent.
        for (int i = 0; i < 400; i++) begin
            int ms, mu;
            ms = ($urandom % 8 == 0) ? 1 : 0;
            mu = (ms != 0 || $urandom % 6 == 0) ? 1 : 0;
            drv(($urandom % 8 != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3), ms, $urandom_range(0, 1),
                mu, ($urandom % 25 == 0) ? 1 : 0);
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
